// File: rtl/video_mux_pipe.sv
// Two-stage pipelined display mux: eight background render modes, crosshair overlay,
// frame-synchronous double-buffered settings, and timing signals delayed to match the pixel.
module video_mux_pipe #(
    parameter int          CH_W        = 8,
    parameter int          H_W         = 11,
    parameter int          V_W         = 10,
    parameter logic [23:0] BIN_COLOR   = 24'h00FF00,
    parameter logic [23:0] MASK_COLOR  = 24'hFF77AA,
    parameter logic [23:0] CROSS_COLOR = 24'hFF0000
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                valid_in,
    input  logic                frame_start_in,
    input  logic [H_W-1:0]      h_count_in,
    input  logic [V_W-1:0]      v_count_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                blank_in,
    input  logic [3*CH_W-1:0]   camera_pixel_in,
    input  logic                bin_in,
    input  logic                thresholded_pixel_in,
    input  logic [2:0]          mode_in,
    input  logic                cross_en_in,
    input  logic [H_W-1:0]      cross_x_in,
    input  logic [V_W-1:0]      cross_y_in,
    output logic [3*CH_W-1:0]   pixel_out,
    output logic                valid_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                blank_out,
    output logic [2:0]          active_mode_out
);

    localparam int PIX_W = 3 * CH_W;
    localparam logic [PIX_W-1:0] BIN_C   = PIX_W'(BIN_COLOR);
    localparam logic [PIX_W-1:0] MASK_C  = PIX_W'(MASK_COLOR);
    localparam logic [PIX_W-1:0] CROSS_C = PIX_W'(CROSS_COLOR);

    // Per-channel average with the mask colour; the extra sum bit prevents wrap.
    function automatic logic [PIX_W-1:0] blend_fn(input logic [PIX_W-1:0] c,
                                                  input logic [PIX_W-1:0] m);
        logic [PIX_W-1:0] res;
        logic [CH_W:0]    sum;
        res = {PIX_W{1'b0}};
        for (int i = 0; i < 3; i++) begin
            sum = {1'b0, c[i*CH_W +: CH_W]} + {1'b0, m[i*CH_W +: CH_W]};
            res[i*CH_W +: CH_W] = CH_W'(sum >> 1);
        end
        return res;
    endfunction

    // Luma approximation (R + 2G + B) / 4 at CH_W+2 bits.
    function automatic logic [CH_W-1:0] luma_fn(input logic [PIX_W-1:0] c);
        logic [CH_W+1:0] y;
        y = {2'b00, c[3*CH_W-1 -: CH_W]} + {1'b0, c[2*CH_W-1 -: CH_W], 1'b0}
          + {2'b00, c[CH_W-1:0]};
        return CH_W'(y >> 2);
    endfunction

    logic                load_s;
    logic [2:0]          mode_sh_r;
    logic                cen_sh_r;
    logic [H_W-1:0]      cx_sh_r;
    logic [V_W-1:0]      cy_sh_r;
    logic [2:0]          eff_mode_s;
    logic                eff_cen_s;
    logic [H_W-1:0]      eff_cx_s;
    logic [V_W-1:0]      eff_cy_s;
    logic                hit_s;

    logic                valid_r1, hsync_r1, vsync_r1, blank_r1;
    logic [2:0]          mode_r1;
    logic [PIX_W-1:0]    cam_r1;
    logic                t_r1, b_r1, hit_r1;
    logic [CH_W-1:0]     luma_r1;
    logic [PIX_W-1:0]    blend_r1;

    logic [PIX_W-1:0]    sel_pix_s;
    logic [PIX_W-1:0]    final_pix_s;

    logic [PIX_W-1:0]    pix_r2;
    logic                valid_r2, hsync_r2, vsync_r2, blank_r2;
    logic [2:0]          mode_r2;

    assign load_s = valid_in && frame_start_in;

    // Shadow settings register, loaded only with a valid frame-start pixel.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_sh_r <= 3'd0;
            cen_sh_r  <= 1'b0;
            cx_sh_r   <= {H_W{1'b0}};
            cy_sh_r   <= {V_W{1'b0}};
        end else if (load_s) begin
            mode_sh_r <= mode_in;
            cen_sh_r  <= cross_en_in;
            cx_sh_r   <= cross_x_in;
            cy_sh_r   <= cross_y_in;
        end else begin
            mode_sh_r <= mode_sh_r;
            cen_sh_r  <= cen_sh_r;
            cx_sh_r   <= cx_sh_r;
            cy_sh_r   <= cy_sh_r;
        end
    end

    // Effective settings: the frame-start pixel bypasses the shadow with the new values.
    always_comb begin
        eff_mode_s = mode_sh_r;
        eff_cen_s  = cen_sh_r;
        eff_cx_s   = cx_sh_r;
        eff_cy_s   = cy_sh_r;
        if (load_s) begin
            eff_mode_s = mode_in;
            eff_cen_s  = cross_en_in;
            eff_cx_s   = cross_x_in;
            eff_cy_s   = cross_y_in;
        end else begin
            eff_mode_s = mode_sh_r;
            eff_cen_s  = cen_sh_r;
            eff_cx_s   = cx_sh_r;
            eff_cy_s   = cy_sh_r;
        end
    end

    assign hit_s = eff_cen_s && ((h_count_in == eff_cx_s) || (v_count_in == eff_cy_s));

    // Stage 1: capture inputs, effective settings and the arithmetic candidates.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_r1 <= 1'b0;
            hsync_r1 <= 1'b0;
            vsync_r1 <= 1'b0;
            blank_r1 <= 1'b0;
            mode_r1  <= 3'd0;
            cam_r1   <= {PIX_W{1'b0}};
            t_r1     <= 1'b0;
            b_r1     <= 1'b0;
            hit_r1   <= 1'b0;
            luma_r1  <= {CH_W{1'b0}};
            blend_r1 <= {PIX_W{1'b0}};
        end else begin
            valid_r1 <= valid_in;
            hsync_r1 <= hsync_in;
            vsync_r1 <= vsync_in;
            blank_r1 <= blank_in;
            mode_r1  <= eff_mode_s;
            cam_r1   <= camera_pixel_in;
            t_r1     <= thresholded_pixel_in;
            b_r1     <= bin_in;
            hit_r1   <= hit_s;
            luma_r1  <= luma_fn(camera_pixel_in);
            blend_r1 <= blend_fn(camera_pixel_in, MASK_C);
        end
    end

    // Background render mode selection.
    always_comb begin
        sel_pix_s = cam_r1;
        case (mode_r1)
            3'd0: sel_pix_s = cam_r1;
            3'd1: sel_pix_s = b_r1 ? BIN_C : cam_r1;
            3'd2: sel_pix_s = t_r1 ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            3'd3: sel_pix_s = t_r1 ? MASK_C : cam_r1;
            3'd4: sel_pix_s = t_r1 ? blend_r1 : cam_r1;
            3'd5: sel_pix_s = {3{luma_r1}};
            3'd6: sel_pix_s = t_r1 ? MASK_C : {3{luma_r1}};
            3'd7: sel_pix_s = cam_r1;
            default: sel_pix_s = cam_r1;
        endcase
    end

    // Blanking beats the overlay, the overlay beats the background.
    always_comb begin
        final_pix_s = sel_pix_s;
        if (blank_r1 || !valid_r1) begin
            final_pix_s = {PIX_W{1'b0}};
        end else if (hit_r1) begin
            final_pix_s = CROSS_C;
        end else begin
            final_pix_s = sel_pix_s;
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pix_r2   <= {PIX_W{1'b0}};
            valid_r2 <= 1'b0;
            hsync_r2 <= 1'b0;
            vsync_r2 <= 1'b0;
            blank_r2 <= 1'b0;
            mode_r2  <= 3'd0;
        end else begin
            pix_r2   <= final_pix_s;
            valid_r2 <= valid_r1;
            hsync_r2 <= hsync_r1;
            vsync_r2 <= vsync_r1;
            blank_r2 <= blank_r1;
            mode_r2  <= mode_r1;
        end
    end

    assign pixel_out       = pix_r2;
    assign valid_out       = valid_r2;
    assign hsync_out       = hsync_r2;
    assign vsync_out       = vsync_r2;
    assign blank_out       = blank_r2;
    assign active_mode_out = mode_r2;

endmodule

// File: tb/tb_video_mux_pipe.sv
// Directed table-driven bench for video_mux_pipe: each vector carries its hand-computed
// output, which is checked two cycles after the vector is applied.
module tb_video_mux_pipe;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        valid_in, frame_start_in;
    logic [10:0] h_count_in;
    logic [9:0]  v_count_in;
    logic        hsync_in, vsync_in, blank_in;
    logic [23:0] camera_pixel_in;
    logic        bin_in, thresholded_pixel_in;
    logic [2:0]  mode_in;
    logic        cross_en_in;
    logic [10:0] cross_x_in;
    logic [9:0]  cross_y_in;
    logic [23:0] pixel_out;
    logic        valid_out, hsync_out, vsync_out, blank_out;
    logic [2:0]  active_mode_out;

    video_mux_pipe dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in),
        .frame_start_in(frame_start_in), .h_count_in(h_count_in), .v_count_in(v_count_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .camera_pixel_in(camera_pixel_in), .bin_in(bin_in),
        .thresholded_pixel_in(thresholded_pixel_in), .mode_in(mode_in),
        .cross_en_in(cross_en_in), .cross_x_in(cross_x_in), .cross_y_in(cross_y_in),
        .pixel_out(pixel_out), .valid_out(valid_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .blank_out(blank_out), .active_mode_out(active_mode_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        fs, valid, blank, hs, vs, t, b, cen;
        logic [2:0]  mode;
        logic [10:0] h, cx;
        logic [9:0]  v, cy;
        logic [23:0] c;
        logic [23:0] exp_pix;
        logic [2:0]  exp_mode;
    } vec_t;

    typedef struct {
        logic [23:0] pix;
        logic        valid, hs, vs, blank;
        logic [2:0]  mode;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    exp_t exp0, exp1;

    function automatic vec_t mk(input logic fs, input logic [2:0] mode, input logic cen,
                                input logic [10:0] cx, input logic [9:0] cy,
                                input logic [10:0] h, input logic [9:0] v,
                                input logic [23:0] c, input logic t, input logic b,
                                input logic [23:0] ep, input logic [2:0] em);
        vec_t r;
        r.fs = fs; r.mode = mode; r.cen = cen; r.cx = cx; r.cy = cy;
        r.h = h; r.v = v; r.c = c; r.t = t; r.b = b;
        r.valid = 1'b1; r.blank = 1'b0; r.hs = 1'b0; r.vs = 1'b0;
        r.exp_pix = ep; r.exp_mode = em;
        return r;
    endfunction

    function automatic vec_t mk_t(input logic valid, input logic blank, input logic hs,
                                  input logic vs, input logic [23:0] c,
                                  input logic [23:0] ep, input logic [2:0] em);
        vec_t r;
        r = mk(1'b0, 3'd3, 1'b1, 11'd1, 10'd1, 11'd1, 10'd1, c, 1'b1, 1'b1, ep, em);
        r.valid = valid; r.blank = blank; r.hs = hs; r.vs = vs;
        return r;
    endfunction

    function automatic exp_t idle_exp(input logic [2:0] m);
        exp_t e;
        e.pix = 24'h000000; e.valid = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.blank = 1'b0;
        e.mode = m;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [23:0] act, input logic [23:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_exp(input exp_t e);
        cmp("pixel_out", pixel_out, e.pix);
        cmp("valid_out", {23'd0, valid_out}, {23'd0, e.valid});
        cmp("hsync_out", {23'd0, hsync_out}, {23'd0, e.hs});
        cmp("vsync_out", {23'd0, vsync_out}, {23'd0, e.vs});
        cmp("blank_out", {23'd0, blank_out}, {23'd0, e.blank});
        cmp("active_mode_out", {21'd0, active_mode_out}, {21'd0, e.mode});
    endtask

    task automatic drive(input vec_t v);
        valid_in = v.valid; frame_start_in = v.fs; blank_in = v.blank;
        hsync_in = v.hs; vsync_in = v.vs; h_count_in = v.h; v_count_in = v.v;
        camera_pixel_in = v.c; thresholded_pixel_in = v.t; bin_in = v.b;
        mode_in = v.mode; cross_en_in = v.cen; cross_x_in = v.cx; cross_y_in = v.cy;
    endtask

    // One pixel per cycle: check the vector applied two cycles ago, then apply the next.
    task automatic step(input vec_t v);
        @(negedge clk_in);
        check_exp(exp1);
        exp1 = exp0;
        drive(v);
        exp0.pix = v.exp_pix; exp0.valid = v.valid; exp0.hs = v.hs; exp0.vs = v.vs;
        exp0.blank = v.blank; exp0.mode = v.exp_mode;
    endtask

    initial begin
        logic [23:0] exp_t1 [8];
        logic [23:0] exp_t0 [8];
        vec_t        idle_v;

        exp_t1 = '{24'h204060, 24'h00FF00, 24'hFFFFFF, 24'hFF77AA,
                   24'h8F5B85, 24'h404040, 24'hFF77AA, 24'h204060};
        exp_t0 = '{24'h204060, 24'h204060, 24'h000000, 24'h204060,
                   24'h204060, 24'h404040, 24'h404040, 24'h204060};

        // Mode sweeps (each vector carries a frame start so the new mode applies at once).
        for (int m = 0; m < 8; m++)
            vecs.push_back(mk(1'b1, 3'(m), 1'b0, 11'd0, 10'd0, 11'd5, 10'd5,
                              24'h204060, 1'b1, 1'b1, exp_t1[m], 3'(m)));
        for (int m = 0; m < 8; m++)
            vecs.push_back(mk(1'b1, 3'(m), 1'b0, 11'd0, 10'd0, 11'd5, 10'd5,
                              24'h204060, 1'b0, 1'b0, exp_t0[m], 3'(m)));
        // Arithmetic corners
        vecs.push_back(mk(1'b1, 3'd4, 1'b0, 11'd0, 10'd0, 11'd5, 10'd5, 24'hFFFFFF, 1'b1, 1'b0, 24'hFFBBD4, 3'd4));
        vecs.push_back(mk(1'b1, 3'd5, 1'b0, 11'd0, 10'd0, 11'd5, 10'd5, 24'hFFFFFF, 1'b1, 1'b0, 24'hFFFFFF, 3'd5));
        vecs.push_back(mk(1'b1, 3'd4, 1'b0, 11'd0, 10'd0, 11'd5, 10'd5, 24'h000000, 1'b1, 1'b0, 24'h7F3B55, 3'd4));
        // Blank and sync alignment in mode 0
        vecs.push_back(mk(1'b1, 3'd0, 1'b0, 11'd0, 10'd0, 11'd1, 10'd1, 24'h0F0F0F, 1'b0, 1'b0, 24'h0F0F0F, 3'd0));
        vecs.push_back(mk_t(1'b1, 1'b1, 1'b1, 1'b0, 24'hC0FFEE, 24'h000000, 3'd0));
        vecs.push_back(mk_t(1'b1, 1'b0, 1'b0, 1'b1, 24'h13579B, 24'h13579B, 3'd0));
        vecs.push_back(mk_t(1'b0, 1'b0, 1'b1, 1'b1, 24'h2468AC, 24'h000000, 3'd0));
        vecs.push_back(mk_t(1'b1, 1'b1, 1'b0, 1'b0, 24'hFEDCBA, 24'h000000, 3'd0));
        vecs.push_back(mk_t(1'b1, 1'b0, 1'b1, 1'b0, 24'h55AA55, 24'h55AA55, 3'd0));
        vecs.push_back(mk_t(1'b1, 1'b0, 1'b0, 1'b0, 24'h000001, 24'h000001, 3'd0));
        // Double buffering: mid-frame mode change waits for the next valid frame start
        vecs.push_back(mk(1'b1, 3'd0, 1'b0, 11'd0, 10'd0, 11'd0, 10'd0, 24'h123456, 1'b1, 1'b0, 24'h123456, 3'd0));
        vecs.push_back(mk(1'b0, 3'd2, 1'b0, 11'd0, 10'd0, 11'd1, 10'd0, 24'h123456, 1'b1, 1'b0, 24'h123456, 3'd0));
        vecs.push_back(mk(1'b0, 3'd2, 1'b0, 11'd0, 10'd0, 11'd2, 10'd0, 24'h123456, 1'b1, 1'b0, 24'h123456, 3'd0));
        vecs.push_back(mk(1'b1, 3'd2, 1'b0, 11'd0, 10'd0, 11'd0, 10'd0, 24'h123456, 1'b1, 1'b0, 24'hFFFFFF, 3'd2));
        vecs.push_back(mk(1'b0, 3'd0, 1'b0, 11'd0, 10'd0, 11'd1, 10'd0, 24'h123456, 1'b0, 1'b0, 24'h000000, 3'd2));
        idle_v = mk(1'b1, 3'd5, 1'b0, 11'd0, 10'd0, 11'd0, 10'd0, 24'h123456, 1'b0, 1'b0, 24'h000000, 3'd2);
        idle_v.valid = 1'b0;
        vecs.push_back(idle_v);
        vecs.push_back(mk(1'b0, 3'd5, 1'b0, 11'd0, 10'd0, 11'd1, 10'd0, 24'h123456, 1'b0, 1'b0, 24'h000000, 3'd2));
        // Crosshair latched at frame start; later cross_*_in changes are ignored
        vecs.push_back(mk(1'b1, 3'd0, 1'b1, 11'd100, 10'd50, 11'd0, 10'd0, 24'h123456, 1'b0, 1'b0, 24'h123456, 3'd0));
        vecs.push_back(mk(1'b0, 3'd0, 1'b1, 11'd100, 10'd50, 11'd100, 10'd10, 24'h123456, 1'b0, 1'b0, 24'hFF0000, 3'd0));
        vecs.push_back(mk(1'b0, 3'd0, 1'b1, 11'd100, 10'd50, 11'd7, 10'd50, 24'h123456, 1'b0, 1'b0, 24'hFF0000, 3'd0));
        vecs.push_back(mk(1'b0, 3'd0, 1'b1, 11'd100, 10'd50, 11'd99, 10'd49, 24'h123456, 1'b0, 1'b0, 24'h123456, 3'd0));
        vecs.push_back(mk(1'b0, 3'd0, 1'b0, 11'd5, 10'd5, 11'd100, 10'd3, 24'h123456, 1'b0, 1'b0, 24'hFF0000, 3'd0));
        idle_v = mk(1'b0, 3'd0, 1'b1, 11'd100, 10'd50, 11'd100, 10'd10, 24'h123456, 1'b0, 1'b0, 24'h000000, 3'd0);
        idle_v.blank = 1'b1; idle_v.hs = 1'b1;
        vecs.push_back(idle_v);
        vecs.push_back(mk(1'b1, 3'd0, 1'b0, 11'd100, 10'd50, 11'd100, 10'd50, 24'h123456, 1'b0, 1'b0, 24'h123456, 3'd0));
        vecs.push_back(mk(1'b0, 3'd0, 1'b0, 11'd100, 10'd50, 11'd100, 10'd7, 24'h654321, 1'b0, 1'b0, 24'h654321, 3'd0));

        idle_v = mk(1'b0, 3'd0, 1'b0, 11'd0, 10'd0, 11'd0, 10'd0, 24'h000000, 1'b0, 1'b0, 24'h000000, 3'd0);
        idle_v.valid = 1'b0;

        // Reset state
        rst_n_in = 1'b0;
        drive(idle_v);
        #3;
        check_exp(idle_exp(3'd0));
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        exp0 = idle_exp(3'd0);
        exp1 = idle_exp(3'd0);

        foreach (vecs[i]) step(vecs[i]);

        // Asynchronous reset mid-stream discards in-flight pixels
        idle_v.exp_mode = 3'd0;
        step(mk(1'b0, 3'd0, 1'b0, 11'd0, 10'd0, 11'd3, 10'd3, 24'hABCDEF, 1'b0, 1'b0, 24'hABCDEF, 3'd0));
        step(mk(1'b0, 3'd0, 1'b0, 11'd0, 10'd0, 11'd4, 10'd3, 24'hABCDEE, 1'b0, 1'b0, 24'hABCDEE, 3'd0));
        step(mk(1'b0, 3'd0, 1'b0, 11'd0, 10'd0, 11'd5, 10'd3, 24'hABCDED, 1'b0, 1'b0, 24'hABCDED, 3'd0));
        #2;
        rst_n_in = 1'b0;
        #1;
        check_exp(idle_exp(3'd0));
        drive(idle_v);
        @(negedge clk_in);
        check_exp(idle_exp(3'd0));
        rst_n_in = 1'b1;
        exp0 = idle_exp(3'd0);
        exp1 = idle_exp(3'd0);

        // First pixel after reset appears exactly two cycles later
        step(mk(1'b1, 3'd0, 1'b0, 11'd0, 10'd0, 11'd0, 10'd0, 24'h123456, 1'b0, 1'b0, 24'h123456, 3'd0));
        step(idle_v);
        step(idle_v);
        step(idle_v);
        step(idle_v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
